// File: rtl/io_cond_pkg.sv
// Shared definitions for the push-button / slide-switch input conditioner.
package io_cond_pkg;

    localparam int unsigned NUM_PB = 2;
    localparam int unsigned NUM_SW = 2;
    localparam int unsigned NUM_CH = NUM_PB + NUM_SW;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } chan_state_e;

    // Bits needed to hold 0..n, i.e. ceil(log2(n+1)), never less than 1
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((33'(1) << w) < (33'(n) + 33'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level and one-cycle rise/fall/change pulses.
// A clean edge reaches o_level DEBOUNCE_CYCLES+2 clocks after the clock edge
// that first registers it: two synchronizer stages, one cycle to enter the
// WAIT state, then DEBOUNCE_CYCLES stable samples counted in WAIT.
module debounce_channel
    import io_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_change
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             w_sample;

    assign w_sample = r_sync[1];

    // Two-stage synchronizer for the raw asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // FSM state, stability counter, level and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state logic; counter saturates at CNT_LAST by leaving WAIT, so it never wraps
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (w_sample) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_sample) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!w_sample) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (w_sample) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_change = r_rise | r_fall;

endmodule

// File: rtl/pb_sw_conditioner.sv
// Board input conditioner: four debounced channels (2 buttons, 2 switches)
// plus wrapping press counters for the two buttons.
module pb_sw_conditioner
    import io_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic              OSC_FPGA,
    input  logic              RST_N,
    input  logic [NUM_PB-1:0] PB,
    input  logic [NUM_SW-1:0] SW,
    output logic [NUM_PB-1:0] PB_LEVEL,
    output logic [NUM_PB-1:0] PB_PRESS,
    output logic [NUM_PB-1:0] PB_RELEASE,
    output logic [NUM_SW-1:0] SW_LEVEL,
    output logic [NUM_SW-1:0] SW_CHANGE,
    output logic [CNT_W-1:0]  PB0_COUNT,
    output logic [CNT_W-1:0]  PB1_COUNT
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] w_change;
    logic [CNT_W-1:0]  r_press_cnt [NUM_PB];
    logic              w_unused;

    // Buttons occupy the low channels, switches the high ones
    assign w_raw = {SW, PB};

    // Independent debounce channel per raw input
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (OSC_FPGA),
            .rst_n    (RST_N),
            .i_raw    (w_raw[g]),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g]),
            .o_change (w_change[g])
        );
    end

    // Press counters advance on the registered press pulse, wrapping silently
    always_ff @(posedge OSC_FPGA or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_PB); i++) begin
                r_press_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_PB); i++) begin
                if (w_rise[i]) begin
                    r_press_cnt[i] <= r_press_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign PB_LEVEL   = w_level[NUM_PB-1:0];
    assign PB_PRESS   = w_rise[NUM_PB-1:0];
    assign PB_RELEASE = w_fall[NUM_PB-1:0];
    assign SW_LEVEL   = w_level[NUM_CH-1:NUM_PB];
    assign SW_CHANGE  = w_change[NUM_CH-1:NUM_PB];
    assign PB0_COUNT  = r_press_cnt[0];
    assign PB1_COUNT  = r_press_cnt[1];

    // Channel outputs with no consumer at this level
    assign w_unused = ^{w_change[NUM_PB-1:0], w_rise[NUM_CH-1:NUM_PB], w_fall[NUM_CH-1:NUM_PB]};

endmodule

// File: tb/tb_pb_sw_conditioner.sv
// Directed bench for pb_sw_conditioner with DEBOUNCE_CYCLES=4, CNT_W=8.
// Inputs change on the falling edge; the following rising edge is the
// capture edge, and accepted levels appear DEB+2 rising edges after it.
module tb_pb_sw_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned LAT = DEB + 2;

    logic          clk;
    logic          rst_n;
    logic [1:0]    pb;
    logic [1:0]    sw;
    logic [1:0]    pb_level;
    logic [1:0]    pb_press;
    logic [1:0]    pb_release;
    logic [1:0]    sw_level;
    logic [1:0]    sw_change;
    logic [CW-1:0] pb0_count;
    logic [CW-1:0] pb1_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_press [2] = '{0, 0};
    int n_rel   [2] = '{0, 0};
    int n_swch  [2] = '{0, 0};

    typedef struct {
        logic [1:0] pb;
        logic [1:0] sw;
        int         hold;
        logic [1:0] pb_lvl;
        logic [1:0] sw_lvl;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t vecs [9];

    pb_sw_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .OSC_FPGA   (clk),
        .RST_N      (rst_n),
        .PB         (pb),
        .SW         (sw),
        .PB_LEVEL   (pb_level),
        .PB_PRESS   (pb_press),
        .PB_RELEASE (pb_release),
        .SW_LEVEL   (sw_level),
        .SW_CHANGE  (sw_change),
        .PB0_COUNT  (pb0_count),
        .PB1_COUNT  (pb1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pb_press[i] === 1'b1)   n_press[i] = n_press[i] + 1;
            if (pb_release[i] === 1'b1) n_rel[i]   = n_rel[i] + 1;
            if (sw_change[i] === 1'b1)  n_swch[i]  = n_swch[i] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({pb_level, pb_press, pb_release, sw_level, sw_change, pb0_count, pb1_count});
    endfunction

    task automatic press_pb0();
        @(negedge clk); pb[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); pb[0] = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        //               pb     sw     hold pb_lvl sw_lvl c0    c1
        vecs[0] = '{2'b11, 2'b11, 10, 2'b11, 2'b11, 8'd2, 8'd1};  // simultaneous presses
        vecs[1] = '{2'b00, 2'b00, 10, 2'b00, 2'b00, 8'd2, 8'd1};  // all channels fall together
        vecs[2] = '{2'b10, 2'b01, 10, 2'b10, 2'b01, 8'd2, 8'd2};
        vecs[3] = '{2'b00, 2'b01,  2, 2'b10, 2'b01, 8'd2, 8'd2};  // PB1 low glitch, 2 samples
        vecs[4] = '{2'b10, 2'b01, 10, 2'b10, 2'b01, 8'd2, 8'd2};
        vecs[5] = '{2'b01, 2'b10, 10, 2'b01, 2'b10, 8'd3, 8'd2};  // PB1 release + PB0 press
        vecs[6] = '{2'b00, 2'b10, 10, 2'b00, 2'b10, 8'd3, 8'd2};
        vecs[7] = '{2'b01, 2'b10,  3, 2'b00, 2'b10, 8'd3, 8'd2};  // PB0 high glitch, 3 samples
        vecs[8] = '{2'b00, 2'b10, 10, 2'b00, 2'b10, 8'd3, 8'd2};

        rst_n = 1'b0;
        pb    = 2'b00;
        sw    = 2'b00;
        tick(3);
        check("reset_outputs", all_out(), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        tick(3);
        check("idle_after_reset", all_out(), 32'h0);

        // Clean PB0 press
        @(negedge clk); pb = 2'b01;
        @(posedge clk); #1;
        tick(LAT - 1);
        check("pb0_press_early_level", 32'(pb_level), 32'h0);
        check("pb0_press_early_pulse", 32'(pb_press), 32'h0);
        tick(1);
        check("pb0_press_level", 32'(pb_level), 32'h1);
        check("pb0_press_pulse", 32'(pb_press), 32'h1);
        tick(1);
        check("pb0_press_pulse_width", 32'(pb_press), 32'h0);
        check("pb0_count_one", 32'(pb0_count), 32'h1);

        // PB1 high for only three samples
        @(negedge clk); pb[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); pb[1] = 1'b0;
        tick(12);
        check("pb1_glitch_level", 32'(pb_level), 32'h1);
        check("pb1_glitch_presses", 32'(n_press[1]), 32'd0);
        check("pb1_glitch_count", 32'(pb1_count), 32'h0);

        // Both switches in one cycle
        @(negedge clk); sw = 2'b11;
        @(posedge clk); #1;
        tick(LAT - 1);
        check("sw_early_level", 32'(sw_level), 32'h0);
        tick(1);
        check("sw_level_both", 32'(sw_level), 32'h3);
        check("sw_change_both", 32'(sw_change), 32'h3);
        tick(1);
        check("sw_change_width", 32'(sw_change), 32'h0);

        // PB0 release
        @(negedge clk); pb[0] = 1'b0;
        @(posedge clk); #1;
        tick(LAT - 1);
        check("pb0_rel_early", 32'({pb_level, pb_release}), 32'h4);
        tick(1);
        check("pb0_rel_level", 32'(pb_level), 32'h0);
        check("pb0_rel_pulse", 32'(pb_release), 32'h1);
        tick(1);
        check("pb0_rel_pulse_width", 32'(pb_release), 32'h0);
        check("pb0_rel_count", 32'(pb0_count), 32'h1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pb = vecs[i].pb;
            sw = vecs[i].sw;
            tick(vecs[i].hold);
            check($sformatf("vec%0d", i),
                  32'({pb_level, sw_level, pb0_count, pb1_count}),
                  32'({vecs[i].pb_lvl, vecs[i].sw_lvl, vecs[i].c0, vecs[i].c1}));
        end
        check("tally_press0", 32'(n_press[0]), 32'd3);
        check("tally_press1", 32'(n_press[1]), 32'd2);
        check("tally_rel0",   32'(n_rel[0]),   32'd3);
        check("tally_rel1",   32'(n_rel[1]),   32'd2);
        check("tally_swch0",  32'(n_swch[0]),  32'd4);
        check("tally_swch1",  32'(n_swch[1]),  32'd3);

        // 256 presses wrap the 8-bit counter back to its starting value (3)
        for (int i = 0; i < 256; i++) begin
            press_pb0();
            #1;
            if (i == 251) check("pb0_count_max", 32'(pb0_count), 32'd255);
            if (i == 252) check("pb0_count_wrap", 32'(pb0_count), 32'd0);
        end
        check("pb0_count_256", 32'(pb0_count), 32'd3);
        check("pb1_count_still", 32'(pb1_count), 32'd2);
        check("tally_press0_256", 32'(n_press[0]), 32'd259);

        // Reset in the middle of a PB0 debounce (FSM two clocks into WAIT_HIGH)
        @(negedge clk); pb[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_out(), 32'h0);
        tick(1);
        check("held_reset_outputs", all_out(), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tick(LAT - 1);
        check("post_reset_early", 32'({pb_level, pb_press, sw_level}), 32'h0);
        tick(1);
        check("post_reset_press", 32'(pb_press), 32'h1);
        check("post_reset_swchg", 32'(sw_change), 32'h2);
        check("post_reset_levels", 32'({pb_level, sw_level}), 32'h6);
        tick(1);
        check("post_reset_counts", 32'({pb0_count, pb1_count}), 32'h0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
